multicycle_lsri_core: RTL and testbench



---
 rtl/mlsri_pkg.sv | 57 +++++
 rtl/mlsri_regfile.sv | 31 +++
 rtl/multicycle_lsri_core.sv | 174 +++++++++++++++++
 tb/tb_multicycle_lsri_core.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mlsri_pkg.sv
// Shared encodings, FSM/ALU enums and the instruction decoder for the
// multi-cycle load/store/R/I core.
package mlsri_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    use_imm;
    logic    sext;
    logic    wen;
    logic    is_lw;
    logic    is_sw;
    logic    rdst;    // destination is rd (R-type) rather than rt
    logic    legal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d = '{op: ALU_ADD, default: 1'b0};
    case (ir[31:26])
      OP_R: begin
        d.rdst = 1'b1; d.wen = 1'b1; d.legal = 1'b1;
        case (ir[5:0])
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_SLT:  d.op = ALU_SLT;
          default: begin d.legal = 1'b0; d.wen = 1'b0; end
        endcase
      end
      OP_ADDI: begin d.use_imm = 1'b1; d.sext = 1'b1; d.wen = 1'b1; d.legal = 1'b1; end
      OP_ANDI: begin d.op = ALU_AND; d.use_imm = 1'b1; d.wen = 1'b1; d.legal = 1'b1; end
      OP_ORI:  begin d.op = ALU_OR;  d.use_imm = 1'b1; d.wen = 1'b1; d.legal = 1'b1; end
      OP_LW:   begin d.use_imm = 1'b1; d.sext = 1'b1; d.wen = 1'b1; d.is_lw = 1'b1; d.legal = 1'b1; end
      OP_SW:   begin d.use_imm = 1'b1; d.sext = 1'b1; d.is_sw = 1'b1; d.legal = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mlsri_regfile.sv
// NREG x XLEN register file: two async read ports, one sync write port,
// R0 and out-of-range indices read as zero and ignore writes.
module mlsri_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      i_ra1,
  output logic [XLEN-1:0] o_rd1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd2,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && i_wa != 5'd0 && 32'(i_wa) < NREG) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0 || 32'(i_ra1) >= NREG) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0 || 32'(i_ra2) >= NREG) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/multicycle_lsri_core.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt/addi/andi/ori/lw/sw).
// Define MLSRI_OVF_TRAP_EN to trap signed overflow on add/sub/addi.
module multicycle_lsri_core
  import mlsri_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter int             NREG     = 32,
  parameter int             AW       = 32,
  parameter logic [AW-1:0]  PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            illegal,
  output logic [AW-1:0]   pc_o
);

  state_t          r_state;
  logic [AW-1:0]   r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a, r_b, r_imm, r_r;
  alu_op_t         r_op;
  logic            r_use_imm, r_wen, r_is_lw, r_is_sw;
  logic [4:0]      r_dst;
  logic            r_imem_req, r_dmem_req, r_dmem_we, r_retire, r_illegal;
  logic [AW-1:0]   r_dmem_addr;
  logic [XLEN-1:0] r_dmem_wdata;

  dec_t            w_dec;
  logic [XLEN-1:0] w_rs_data, w_rt_data, w_imm, w_opb, w_sum, w_diff, w_alu;
  logic            w_we, w_trap;

  assign w_dec = decode(r_ir);
  assign w_imm = w_dec.sext ? XLEN'($signed(r_ir[15:0])) : XLEN'(r_ir[15:0]);
  assign w_opb = r_use_imm ? r_imm : r_b;
  assign w_sum  = r_a + w_opb;
  assign w_diff = r_a - w_opb;

  always_comb begin
    case (r_op)
      ALU_SUB: w_alu = w_diff;
      ALU_AND: w_alu = r_a & w_opb;
      ALU_OR:  w_alu = r_a | w_opb;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(w_opb)};
      default: w_alu = w_sum;
    endcase
  end

`ifdef MLSRI_OVF_TRAP_EN
  logic w_ovf, r_ovf;
  // Address arithmetic of lw/sw never traps.
  always_comb begin
    w_ovf = 1'b0;
    if (!r_is_lw && !r_is_sw) begin
      if (r_op == ALU_ADD)
        w_ovf = (r_a[XLEN-1] == w_opb[XLEN-1]) && (w_sum[XLEN-1] != r_a[XLEN-1]);
      else if (r_op == ALU_SUB)
        w_ovf = (r_a[XLEN-1] != w_opb[XLEN-1]) && (w_diff[XLEN-1] != r_a[XLEN-1]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_ovf <= 1'b0;
    else if (r_state == S_EXEC)   r_ovf <= w_ovf;
  end
  assign w_trap = r_ovf;
`else
  assign w_trap = 1'b0;
`endif

  assign w_we = (r_state == S_WB) && r_wen && !w_trap;

  mlsri_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (r_ir[25:21]),
    .o_rd1 (w_rs_data),
    .i_ra2 (r_ir[20:16]),
    .o_rd2 (w_rt_data),
    .i_we  (w_we),
    .i_wa  (r_dst),
    .i_wd  (r_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;   r_pc <= PC_RESET;   r_ir <= '0;
      r_a <= '0; r_b <= '0; r_imm <= '0; r_r <= '0;
      r_op <= ALU_ADD; r_use_imm <= 1'b0; r_wen <= 1'b0;
      r_is_lw <= 1'b0; r_is_sw <= 1'b0; r_dst <= '0;
      r_imem_req <= 1'b0; r_dmem_req <= 1'b0; r_dmem_we <= 1'b0;
      r_dmem_addr <= '0; r_dmem_wdata <= '0;
      r_retire <= 1'b0; r_illegal <= 1'b0;
    end else begin
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (r_imem_req && imem_ready) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          r_a <= w_rs_data; r_b <= w_rt_data; r_imm <= w_imm;
          r_op <= w_dec.op; r_use_imm <= w_dec.use_imm; r_wen <= w_dec.wen;
          r_is_lw <= w_dec.is_lw; r_is_sw <= w_dec.is_sw;
          r_dst <= w_dec.rdst ? r_ir[15:11] : r_ir[20:16];
          if (!w_dec.legal) begin
            r_illegal <= 1'b1; r_retire <= 1'b1;
            r_pc <= r_pc + 1'b1; r_imem_req <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_r <= w_alu;
          if (r_is_lw || r_is_sw) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= r_is_sw;
            r_dmem_addr  <= AW'(w_alu);
            r_dmem_wdata <= r_b;
            r_state      <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (r_dmem_req && dmem_ready) begin
            r_dmem_req <= 1'b0;
            if (r_is_sw) begin
              r_retire <= 1'b1; r_pc <= r_pc + 1'b1;
              r_imem_req <= 1'b1; r_state <= S_FETCH;
            end else begin
              r_r <= dmem_rdata; r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_retire   <= !w_trap;
          r_illegal  <= w_trap;
          r_pc       <= r_pc + 1'b1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign retire     = r_retire;
  assign illegal    = r_illegal;
  assign pc_o       = r_pc;

endmodule

// File: tb/tb_multicycle_lsri_core.sv
// Directed bench for multicycle_lsri_core: a small program with
// hand-computed register results, handshake stalls and a mid-fetch reset.
module tb_multicycle_lsri_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        retire, illegal;
  logic [31:0] pc_o;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int dwait = 0;
  int dcnt  = 0;
  int cyc   = 0;
  int dreq_cyc = 0;
  logic unstable = 1'b0;
  logic prev_req = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic prev_we;

  int errors = 0;
  int checks = 0;
  int last_t = 0;

  multicycle_lsri_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .illegal(illegal), .pc_o(pc_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_rdata = (imem_addr < 32'd64) ? imem[imem_addr[5:0]] : 32'h0;
  assign dmem_rdata = (dmem_addr < 32'd64) ? dmem[dmem_addr[5:0]] : 32'h0;
  assign dmem_ready = dmem_req && (dcnt >= dwait);

  always @(posedge clk) begin
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we && dmem_addr < 32'd64)
      dmem[dmem_addr[5:0]] <= dmem_wdata;
  end

  // Request-stability monitor for the data port.
  always @(negedge clk) begin
    if (dmem_req) begin
      dreq_cyc <= dreq_cyc + 1;
      if (prev_req && (dmem_addr !== prev_addr || dmem_we !== prev_we || dmem_wdata !== prev_wdata))
        unstable <= 1'b1;
    end
    prev_req <= dmem_req; prev_addr <= dmem_addr; prev_we <= dmem_we; prev_wdata <= dmem_wdata;
  end

  function automatic logic [31:0] rg(input int n);
    return dut.u_rf.r_regs[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the next retire/illegal pulse; check its gap and pulse kinds.
  task automatic step(input string tag, input int gap, input logic eret, input logic eill);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (retire || illegal) seen = 1'b1;
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (gap >= 0) chk({tag, "_gap"}, cyc - last_t, gap);
    chk({tag, "_retire"}, {31'd0, retire}, {31'd0, eret});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, eill});
    last_t = cyc;
  endtask

  initial begin
    int d0;
    logic trap;
`ifdef MLSRI_OVF_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    for (int i = 0; i < 64; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
    imem[0]  = 32'h20010014; // addi R1,R0,20
    imem[1]  = 32'h2002FFFF; // addi R2,R0,-1
    imem[2]  = 32'h00221820; // add  R3,R1,R2
    imem[3]  = 32'hAC010002; // sw   R1,2(R0)
    imem[4]  = 32'h8C040005; // lw   R4,5(R0)
    imem[5]  = 32'h00812822; // sub  R5,R4,R1
    imem[6]  = 32'hFC000000; // unsupported opcode
    imem[7]  = 32'h340600FF; // ori  R6,R0,0x00FF
    imem[8]  = 32'h20000005; // addi R0,R0,5
    imem[9]  = 32'h8C070006; // lw   R7,6(R0)
    imem[10] = 32'h20E20001; // addi R2,R7,1
    imem[11] = 32'h0041482A; // slt  R9,R2,R1
    imem[12] = 32'h0022502A; // slt  R10,R1,R2
    imem[13] = 32'h00615824; // and  R11,R3,R1
    imem[14] = 32'h00616025; // or   R12,R3,R1
    imem[15] = 32'h30AD8001; // andi R13,R5,0x8001
    imem[16] = 32'h00217000; // R-type, funct 0 (unsupported)
    dmem[5] = 32'd8;
    dmem[6] = 32'h7FFFFFFF;
    imem_ready = 1'b1;
    dwait = 2;

    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_retire",   {31'd0, retire},   32'd0);
    chk("rst_illegal",  {31'd0, illegal},  32'd0);
    chk("rst_pc",       pc_o,              32'd0);

    rst = 1'b1;
    @(negedge clk);
    chk("imem_req_rise", {31'd0, imem_req}, 32'd1);
    last_t = cyc;

    step("addi1", -1, 1'b1, 1'b0);  chk("R1", rg(1), 32'd20);
    step("addi2",  4, 1'b1, 1'b0);  chk("R2", rg(2), 32'hFFFFFFFF);
    step("add",    4, 1'b1, 1'b0);  chk("R3", rg(3), 32'd19);
    chk("pc_after_add", pc_o, 32'd3);

    d0 = dreq_cyc;
    step("sw", 6, 1'b1, 1'b0);
    dwait = 0;
    chk("sw_req_cycles", dreq_cyc - d0, 32'd3);
    chk("sw_mem2", dmem[2], 32'd20);
    chk("sw_stable", {31'd0, unstable}, 32'd0);

    step("lw",  5, 1'b1, 1'b0);  chk("R4", rg(4), 32'd8);
    step("sub", 4, 1'b1, 1'b0);  chk("R5", rg(5), 32'hFFFFFFF4);
    step("bad_op", 2, 1'b1, 1'b1);
    chk("pc_after_bad_op", pc_o, 32'd7);
    step("ori", 4, 1'b1, 1'b0);  chk("R6", rg(6), 32'd255);
    chk("R5_intact", rg(5), 32'hFFFFFFF4);
    step("addi_r0", 4, 1'b1, 1'b0);  chk("R0", rg(0), 32'd0);
    step("lw_r7", 5, 1'b1, 1'b0);    chk("R7", rg(7), 32'h7FFFFFFF);
    step("addi_ovf", 4, !trap, trap);
    chk("R2_ovf", rg(2), trap ? 32'hFFFFFFFF : 32'h80000000);
    step("slt_neg", 4, 1'b1, 1'b0);  chk("R9", rg(9), 32'd1);
    step("slt_pos", 4, 1'b1, 1'b0);  chk("R10", rg(10), 32'd0);
    step("and", 4, 1'b1, 1'b0);      chk("R11", rg(11), 32'd16);
    step("or",  4, 1'b1, 1'b0);      chk("R12", rg(12), 32'd23);
    step("andi", 4, 1'b1, 1'b0);     chk("R13", rg(13), 32'h00008000);
    step("bad_funct", 2, 1'b1, 1'b1);
    imem_ready = 1'b0;
    chk("R14", rg(14), 32'd0);

    repeat (3) @(negedge clk);
    chk("stall_imem_req", {31'd0, imem_req}, 32'd1);
    chk("stall_addr", imem_addr, 32'd17);
    #2 rst = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc_o, 32'd0);
    chk("async_regs", rg(3), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    last_t = cyc;
    step("restart", -1, 1'b1, 1'b0);
    chk("restart_R1", rg(1), 32'd20);
    chk("restart_pc", pc_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
